// File: rtl/lc3b_pkg.sv
// Shared constants and types for the LC-3b microsequencer slice: control
// word field positions, COND encodings and the reset microstate.
package lc3b_pkg;

    localparam int UADDR_W = 6;
    localparam int CW_W    = 35;

    localparam int IRD_BIT = 34;
    localparam int COND_HI = 33;
    localparam int COND_LO = 32;
    localparam int J_HI    = 31;
    localparam int J_LO    = 26;
    localparam int CTRL_HI = 25;

    typedef enum logic [1:0] {
        COND_NONE     = 2'b00,
        COND_MEMRDY   = 2'b01,
        COND_BRANCH   = 2'b10,
        COND_ADDRMODE = 2'b11
    } cond_e;

    localparam logic [UADDR_W-1:0] FETCH_STATE = 6'd18;

    // Control word as laid out in the store, MSB first.
    typedef struct packed {
        logic                ird;
        cond_e               cond;
        logic [UADDR_W-1:0]  j;
        logic [CTRL_HI:0]    ctl;
    } uword_t;

endpackage

// File: rtl/lc3b_microsequencer_if.sv
// Bundle between the microsequencer, the control store and the datapath.
// master = environment (store + datapath), slave = microsequencer.
interface lc3b_microsequencer_if
    import lc3b_pkg::*;
();
    logic               en;
    logic [15:0]        ir;
    logic               ben;
    logic               mem_r;
    logic [CW_W-1:0]    uword;
    logic [UADDR_W-1:0] uaddr;
    logic [CW_W-1:0]    ctrl;
    logic               err;
    logic [15:0]        icount;

    modport master (
        output en, ir, ben, mem_r, uword,
        input  uaddr, ctrl, err, icount
    );

    modport slave (
        input  en, ir, ben, mem_r, uword,
        output uaddr, ctrl, err, icount
    );
endinterface

// File: rtl/lc3b_next_uaddr.sv
// Combinational next-microstate: IRD dispatch on the opcode, otherwise J
// with condition bits OR'd into its low three bits.
module lc3b_next_uaddr
    import lc3b_pkg::*;
(
    input  logic [CW_W-1:0]    uword,
    input  logic [15:0]        ir,
    input  logic               ben,
    input  logic               mem_r,
    output logic [UADDR_W-1:0] next
);

    uword_t uw;
    assign uw = uword_t'(uword);

    // Dispatch or conditional branch off J; a memory wait falls back to J.
    always_comb begin
        next = uw.j;
        if (uw.ird) begin
            next = {2'b00, ir[15:12]};
        end else begin
            next[2] = uw.j[2] | ((uw.cond == COND_BRANCH)   & ben);
            next[1] = uw.j[1] | ((uw.cond == COND_MEMRDY)   & mem_r);
            next[0] = uw.j[0] | ((uw.cond == COND_ADDRMODE) & ir[11]);
        end
    end

endmodule

// File: rtl/lc3b_microsequencer.sv
// LC-3b microsequencer: owns the microstate register, the sticky
// unpopulated-word error/halt and the instruction dispatch counter.
module lc3b_microsequencer
    import lc3b_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    lc3b_microsequencer_if.slave  bus
);

    logic [UADDR_W-1:0] state_q;
    logic [UADDR_W-1:0] next;
    logic               err_q;
    logic               halted_q;
    logic [15:0]        icount_q;
    logic               live;
    logic               zero_word;

    // An edge only does work when enabled and not halted.
    assign live      = bus.en & ~halted_q;
    assign zero_word = (bus.uword == '0);

    lc3b_next_uaddr u_next (
        .uword (bus.uword),
        .ir    (bus.ir),
        .ben   (bus.ben),
        .mem_r (bus.mem_r),
        .next  (next)
    );

    // State, error and counter; a zero word halts and pins the bad state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FETCH_STATE;
            err_q    <= 1'b0;
            halted_q <= 1'b0;
            icount_q <= 16'h0000;
        end else if (live) begin
            if (zero_word) begin
                err_q    <= 1'b1;
                halted_q <= 1'b1;
            end else begin
                state_q <= next;
                if (bus.uword[IRD_BIT])
                    icount_q <= icount_q + 16'h0001;
            end
        end
    end

    // Sequencing fields pass straight through; loads/gates only when live.
    assign bus.ctrl   = {bus.uword[CW_W-1:J_LO], live ? bus.uword[CTRL_HI:0] : {(CTRL_HI+1){1'b0}}};
    assign bus.uaddr  = state_q;
    assign bus.err    = err_q;
    assign bus.icount = icount_q;

endmodule

// File: doc/lc3b_microsequencer.md
# lc3b_microsequencer

Microsequencer that reads the LC-3b 64-entry × 35-bit microcode control store and walks it one microstate per enabled cycle. It presents the current microstate as the store read address, decodes IRD/COND/J from the returned word and computes the next microstate from IR, BEN and memory-ready R. It passes the datapath control field to the datapath and latches an error on any unpopulated (all-zero) word. It sits between the control-store ROM and the LC-3b datapath.

## Interface
- UADDR_W, 6, microstate/store address width
- CW_W, 35, control word width
- FETCH_STATE, 18, microstate entered on reset
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  advance enable; 0 = stall
- ir  in  16  instruction register
- ben  in  1  branch-enable from datapath
- mem_r  in  1  memory ready (R)
- uword  in  CW_W  control store data at `uaddr`; combinational read
- uaddr  out  UADDR_W  current microstate, also the store read address
- ctrl  out  CW_W  control word to datapath
- err  out  1  unpopulated-microstate error, sticky
- icount  out  16  count of IRD dispatches (instructions decoded)

## Operation
- Word fields: bit 34 is IRD, bits 33:32 are COND, bits 31:26 are J, bits 25:0 are datapath controls.
- COND encodings: 00 is unconditional, 01 is memory ready, 10 is branch, 11 is addressing mode.
- Next state when IRD=1 is {2'b00, ir[15:12]}.
- Next state when IRD=0 is J with low bits OR'd:
  - bit 2 |= (COND==10 & ben)
  - bit 1 |= (COND==01 & mem_r)
  - bit 0 |= (COND==11 & ir[11])
- Memory wait: with COND=01 and mem_r=0, the next state is J, so a word whose J equals its own state self-loops.
- `uaddr` = state register (combinational from the flop).
- `ctrl[34:26]` = `uword[34:26]` always.
- `ctrl[25:0]` = `uword[25:0]` when en=1 and halted=0, otherwise 0. A stall or halt therefore never asserts a load or gate.
- Error detection: if `uword`==0 on an enabled edge while not halted:
  - err and halted set on that edge;
  - the state register holds the offending microstate;
  - icount freezes.
- err and halted clear only via rst.
- icount increments on each enabled, non-halted edge where IRD=1. It is a 16-bit counter that wraps 0xFFFF→0x0000.

## Timing
- Async reset values: state=FETCH_STATE (uaddr=18), err=0, halted=0, icount=0. `ctrl` follows `uword` at state 18 (low field live once en=1).
- One microstate per enabled clk edge. Next-state logic is single-cycle combinational from `uword`, ir, ben, mem_r.
- Inputs are sampled at the rising edge only; glitches between edges are ignored.
- en=0 holds state, err and icount, and forces `ctrl[25:0]`=0.
- Simultaneous zero word and IRD is impossible (zero word has IRD=0). Error takes priority over any state update.
- Reset mid-operation (e.g. during a memory wait): state returns to 18 asynchronously, with no completion of the pending transition.
- Microstate addresses are 6 bits; the IRD dispatch reaches only 0–15. J values index 0–63 and need no range check.

## Structure
- Shared package lc3b_pkg:
  - IRD_BIT=34, COND_HI=33, COND_LO=32, J_HI=31, J_LO=26, CTRL_HI=25
  - COND_NONE=2'b00, COND_MEMRDY=2'b01, COND_BRANCH=2'b10, COND_ADDRMODE=2'b11
  - FETCH_STATE=6'd18
- Sub-module lc3b_next_uaddr: purely combinational next-state computation (uword fields, ir, ben, mem_r → 6-bit next). Instantiated once; the parent owns state, halt, err and icount flops.

## Test plan
- Reset: assert rst mid-cycle → uaddr=18, err=0, icount=0 immediately. Deassert with en=1 → next edge uaddr=33.
- Fetch wait: at state 33 hold mem_r=0 for 3 edges → uaddr stays 33. mem_r=1 → 35, then 32. ir=0x1042 → uaddr=1, icount=1; next edge → 18.
- Branch: ir=0x0E05 dispatch → state 0. ben=1 → 22; repeat with ben=0 → 18.
- Addressing mode: ir=0x4800 dispatch → state 4 → 21. ir=0x4000 → 20.
- Unpopulated: ir=0x8000 dispatch → state 8 (word 0). Next edge: err=1, uaddr held at 8, ctrl[25:0]=0, icount frozen across 5 more edges. rst clears everything to the reset values.
- Stall and wrap:
  - en=0 for 4 edges at state 35 → uaddr=35, ctrl[25:0]=0.
  - Preload icount to 0xFFFF via 65535 dispatches, or a force in the bench; next dispatch → icount=0x0000.
